// File: rtl/nios_128k_base_mem_fill_check_master_if.sv
// Avalon-MM bus between the fill/check initiator and the on-chip memory slave.
interface nios_128k_base_mem_fill_check_master_if #(
    parameter int ADDR_W = 17
);
    logic [ADDR_W-1:0] avm_address;
    logic [3:0]        avm_byteenable;
    logic              avm_chipselect;
    logic              avm_write;
    logic              avm_read;
    logic [31:0]       avm_writedata;
    logic [31:0]       avm_readdata;
    logic              avm_waitrequest;
    logic              avm_readdatavalid;

    modport master (
        output avm_address, avm_byteenable, avm_chipselect, avm_write, avm_read, avm_writedata,
        input  avm_readdata, avm_waitrequest, avm_readdatavalid
    );

    modport slave (
        input  avm_address, avm_byteenable, avm_chipselect, avm_write, avm_read, avm_writedata,
        output avm_readdata, avm_waitrequest, avm_readdatavalid
    );
endinterface

// File: rtl/nios_128k_base_mem_fill_check_master.sv
// Memory bring-up initiator: FILL writes a seed/increment pattern over a word range,
// CHECK reads it back with up to MAX_OUT reads in flight and counts mismatches.
module nios_128k_base_mem_fill_check_master #(
    parameter int ADDR_W  = 17,
    parameter int LEN_W   = 15,
    parameter int MAX_OUT = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              op,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  num_words,
    input  logic [31:0]       seed,
    input  logic              incr,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    nios_128k_base_mem_fill_check_master_if.master avm
);
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Issue counter is one bit wider so "all issued" compares cleanly against num_words.
    localparam int                CNT_W     = LEN_W + 1;
    localparam logic [3:0]        MAX_OUT_C = 4'(MAX_OUT);
    localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(4);
    localparam logic [LEN_W-1:0]  ERR_SAT   = {LEN_W{1'b1}};

    // Next pattern word: seed+i when incrementing, constant seed otherwise.
    function automatic logic [31:0] pattern_step(input logic [31:0] word, input logic inc);
        pattern_step = word + {31'd0, inc};
    endfunction

    state_t            state_r, state_d;
    logic [LEN_W-1:0]  num_r;
    logic              incr_r;
    logic [CNT_W-1:0]  issue_cnt_r;
    logic [3:0]        outst_r;
    logic [ADDR_W-1:0] ret_addr_r;
    logic [31:0]       exp_data_r;
    logic [LEN_W-1:0]  err_count_r;
    logic [ADDR_W-1:0] first_err_addr_r;

    logic [ADDR_W-1:0] addr_r, addr_d;
    logic [31:0]       wdata_r, wdata_d;
    logic              write_r, write_d;
    logic              read_r, read_d;
    logic              busy_r, busy_d;
    logic              done_r, done_d;

    logic              start_ok_s;
    logic              num_zero_s;
    logic [ADDR_W-1:0] base_aligned_s;
    logic              wr_accept_s;
    logic              rd_accept_s;
    logic              rdv_s;
    logic              mismatch_s;
    logic [CNT_W-1:0]  issue_next_s;
    logic              issue_all_s;
    logic [3:0]        outst_next_s;

    assign start_ok_s     = (state_r == ST_IDLE) && start;
    assign num_zero_s     = (num_words == {LEN_W{1'b0}});
    assign base_aligned_s = {base_addr[ADDR_W-1:2], 2'b00};
    assign wr_accept_s    = (state_r == ST_WRITE) && write_r && !avm.avm_waitrequest;
    assign rd_accept_s    = (state_r == ST_READ) && read_r && !avm.avm_waitrequest;
    // Read data only counts while a CHECK is waiting for it.
    assign rdv_s          = avm.avm_readdatavalid && ((state_r == ST_READ) || (state_r == ST_DRAIN));
    assign mismatch_s     = rdv_s && (avm.avm_readdata != exp_data_r);
    assign issue_next_s   = issue_cnt_r + {{LEN_W{1'b0}}, (wr_accept_s | rd_accept_s)};
    assign issue_all_s    = (issue_next_s == {1'b0, num_r});
    assign outst_next_s   = outst_r + {3'b000, rd_accept_s} - {3'b000, rdv_s};

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!start) begin
                    state_d = ST_IDLE;
                end else if (num_zero_s) begin
                    state_d = ST_DONE;
                end else if (op) begin
                    state_d = ST_READ;
                end else begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (wr_accept_s && issue_all_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_WRITE;
                end
            end
            ST_READ: begin
                if (issue_all_s) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_READ;
                end
            end
            ST_DRAIN: begin
                if (outst_r == 4'd0) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Next values of the registered bus and status outputs; a stalled request is held untouched.
    always_comb begin
        addr_d  = addr_r;
        wdata_d = wdata_r;
        write_d = 1'b0;
        read_d  = 1'b0;
        busy_d  = (state_d == ST_WRITE) || (state_d == ST_READ) || (state_d == ST_DRAIN);
        done_d  = (state_d == ST_DONE);
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    addr_d  = base_aligned_s;
                    wdata_d = seed;
                    write_d = !op && !num_zero_s;
                    read_d  = op && !num_zero_s;
                end else begin
                    write_d = 1'b0;
                    read_d  = 1'b0;
                end
            end
            ST_WRITE: begin
                if (!wr_accept_s) begin
                    write_d = 1'b1;
                end else if (issue_all_s) begin
                    write_d = 1'b0;
                end else begin
                    write_d = 1'b1;
                    addr_d  = addr_r + WORD_STEP;
                    wdata_d = pattern_step(wdata_r, incr_r);
                end
            end
            ST_READ: begin
                if (read_r && avm.avm_waitrequest) begin
                    read_d = 1'b1;
                end else begin
                    read_d = !issue_all_s && (outst_next_s < MAX_OUT_C);
                    if (rd_accept_s) begin
                        addr_d = addr_r + WORD_STEP;
                    end else begin
                        addr_d = addr_r;
                    end
                end
            end
            ST_DRAIN: read_d = 1'b0;
            ST_DONE:  read_d = 1'b0;
            default:  read_d = 1'b0;
        endcase
    end

    // Output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_r  <= {ADDR_W{1'b0}};
            wdata_r <= 32'd0;
            write_r <= 1'b0;
            read_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            addr_r  <= addr_d;
            wdata_r <= wdata_d;
            write_r <= write_d;
            read_r  <= read_d;
            busy_r  <= busy_d;
            done_r  <= done_d;
        end
    end

    // Command latch, issue/outstanding counters and read-back comparison.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            num_r            <= {LEN_W{1'b0}};
            incr_r           <= 1'b0;
            issue_cnt_r      <= {CNT_W{1'b0}};
            outst_r          <= 4'd0;
            ret_addr_r       <= {ADDR_W{1'b0}};
            exp_data_r       <= 32'd0;
            err_count_r      <= {LEN_W{1'b0}};
            first_err_addr_r <= {ADDR_W{1'b0}};
        end else if (start_ok_s) begin
            num_r            <= num_words;
            incr_r           <= incr;
            issue_cnt_r      <= {CNT_W{1'b0}};
            outst_r          <= 4'd0;
            ret_addr_r       <= base_aligned_s;
            exp_data_r       <= seed;
            err_count_r      <= {LEN_W{1'b0}};
            first_err_addr_r <= {ADDR_W{1'b0}};
        end else begin
            if (wr_accept_s || rd_accept_s) begin
                issue_cnt_r <= issue_next_s;
            end
            outst_r <= outst_next_s;
            if (rdv_s) begin
                ret_addr_r <= ret_addr_r + WORD_STEP;
                exp_data_r <= pattern_step(exp_data_r, incr_r);
                if (mismatch_s) begin
                    if (err_count_r != ERR_SAT) begin
                        err_count_r <= err_count_r + LEN_W'(1);
                    end
                    if (err_count_r == {LEN_W{1'b0}}) begin
                        first_err_addr_r <= ret_addr_r;
                    end
                end
            end
        end
    end

    assign busy               = busy_r;
    assign done               = done_r;
    assign err_count          = err_count_r;
    assign first_err_addr     = first_err_addr_r;
    assign avm.avm_address    = addr_r;
    assign avm.avm_byteenable = 4'hF;
    assign avm.avm_chipselect = write_r | read_r;
    assign avm.avm_write      = write_r;
    assign avm.avm_read       = read_r;
    assign avm.avm_writedata  = wdata_r;
endmodule

// File: tb/tb_nios_128k_base_mem_fill_check_master.sv
// Directed bench: a vector table of FILL/CHECK commands against a memory model,
// plus hand sequences for write stall, zero length, read throttling and mid-command reset.
module tb_nios_128k_base_mem_fill_check_master;
    logic        clk;
    logic        reset_n;
    logic        start;
    logic        op;
    logic [16:0] base_addr;
    logic [14:0] num_words;
    logic [31:0] seed;
    logic        incr;
    logic        busy;
    logic        done;
    logic [14:0] err_count;
    logic [16:0] first_err_addr;

    nios_128k_base_mem_fill_check_master_if #(.ADDR_W(17)) avm ();

    nios_128k_base_mem_fill_check_master #(.ADDR_W(17), .LEN_W(15), .MAX_OUT(4)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op), .base_addr(base_addr),
        .num_words(num_words), .seed(seed), .incr(incr), .busy(busy), .done(done),
        .err_count(err_count), .first_err_addr(first_err_addr), .avm(avm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Memory slave model: zero-wait unless the bench raises waitrequest; reads answered
    // one per clock in order while rsp_en is high.
    logic [31:0] mem [0:32767];
    logic [16:0] wr_addr_q [$];
    logic [31:0] wr_data_q [$];
    int          wr_cyc_q  [$];
    logic [31:0] rsp_q     [$];
    logic        rsp_en;
    int cyc = 0;
    int rd_cnt = 0;
    int cs_seen = 0;
    int outst_m = 0;
    int outst_max = 0;
    int viol = 0;

    always @(posedge clk) begin
        logic acc_rd;
        acc_rd = 1'b0;
        cyc++;
        if (avm.avm_chipselect !== (avm.avm_write | avm.avm_read) || (avm.avm_write && avm.avm_read))
            viol++;
        if (avm.avm_chipselect) cs_seen++;
        if (avm.avm_chipselect && !avm.avm_waitrequest) begin
            if (avm.avm_write) begin
                mem[avm.avm_address[16:2]] = avm.avm_writedata;
                wr_addr_q.push_back(avm.avm_address);
                wr_data_q.push_back(avm.avm_writedata);
                wr_cyc_q.push_back(cyc);
            end
            if (avm.avm_read) begin
                rsp_q.push_back(mem[avm.avm_address[16:2]]);
                acc_rd = 1'b1;
                rd_cnt++;
            end
        end
        if (avm.avm_readdatavalid) outst_m--;
        if (acc_rd) outst_m++;
        if (outst_m > outst_max) outst_max = outst_m;
        #1;
        if (rsp_en && rsp_q.size() > 0) begin
            avm.avm_readdata = rsp_q.pop_front();
            avm.avm_readdatavalid = 1'b1;
        end else begin
            avm.avm_readdatavalid = 1'b0;
        end
    end

    typedef struct {
        logic        op;
        logic [16:0] base;
        logic [14:0] n;
        logic [31:0] seed;
        logic        incr;
        int          corrupt;
        int          exp_lat;
        int          exp_nwr;
        logic [16:0] exp_first_a;
        logic [16:0] exp_last_a;
        logic [31:0] exp_first_d;
        logic [31:0] exp_last_d;
        logic [14:0] exp_err;
        logic [16:0] exp_fea;
    } vec_t;

    vec_t vecs [9];
    int   lat;
    logic timed_out;
    logic busy_first;

    // Issue one command and wait (bounded) for done; lat = negedges from start acceptance to done.
    task automatic run_cmd(input logic o, input logic [16:0] b, input logic [14:0] n,
                           input logic [31:0] s, input logic inc,
                           output int l, output logic to, output logic bf);
        @(negedge clk);
        op = o; base_addr = b; num_words = n; seed = s; incr = inc; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bf = busy;
        l = 1;
        while (!done && l < 2000) begin
            @(negedge clk);
            l++;
        end
        to = !done;
    endtask

    task automatic clear_logs();
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_cyc_q.delete();
        outst_max = 0;
    endtask

    int rd_before;
    int cs_before;
    int wt;
    logic [14:0] widx;

    initial begin
        reset_n = 1'b0; start = 1'b0; op = 1'b0; base_addr = 17'h0; num_words = 15'd0;
        seed = 32'd0; incr = 1'b0; rsp_en = 1'b1;
        avm.avm_waitrequest = 1'b0; avm.avm_readdatavalid = 1'b0; avm.avm_readdata = 32'd0;

        vecs[0] = '{1'b0, 17'h00100, 15'd4, 32'hA5A50000, 1'b1, -1, 5, 4, 17'h00100, 17'h0010C, 32'hA5A50000, 32'hA5A50003, 15'd0, 17'h0};
        vecs[1] = '{1'b1, 17'h00100, 15'd4, 32'hA5A50000, 1'b1, -1, 7, 0, 17'h0, 17'h0, 32'h0, 32'h0, 15'd0, 17'h0};
        vecs[2] = '{1'b1, 17'h00100, 15'd4, 32'hA5A50000, 1'b1,  2, 7, 0, 17'h0, 17'h0, 32'h0, 32'h0, 15'd1, 17'h00108};
        vecs[3] = '{1'b0, 17'h1FFFC, 15'd2, 32'h12345678, 1'b0, -1, 3, 2, 17'h1FFFC, 17'h00000, 32'h12345678, 32'h12345678, 15'd0, 17'h0};
        vecs[4] = '{1'b1, 17'h1FFFC, 15'd2, 32'h12345678, 1'b0, -1, 5, 0, 17'h0, 17'h0, 32'h0, 32'h0, 15'd0, 17'h0};
        vecs[5] = '{1'b1, 17'h00100, 15'd4, 32'hA5A50000, 1'b0, -1, 7, 0, 17'h0, 17'h0, 32'h0, 32'h0, 15'd3, 17'h00104};
        vecs[6] = '{1'b1, 17'h00102, 15'd1, 32'hA5A50000, 1'b1, -1, 4, 0, 17'h0, 17'h0, 32'h0, 32'h0, 15'd0, 17'h0};
        vecs[7] = '{1'b0, 17'h00200, 15'd3, 32'hFFFFFFFF, 1'b1, -1, 4, 3, 17'h00200, 17'h00208, 32'hFFFFFFFF, 32'h00000001, 15'd0, 17'h0};
        vecs[8] = '{1'b1, 17'h00200, 15'd3, 32'hFFFFFFFE, 1'b1, -1, 6, 0, 17'h0, 17'h0, 32'h0, 32'h0, 15'd3, 17'h00200};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'(1'b0));
        chk("rst_done", 64'(done), 64'(1'b0));
        chk("rst_err_count", 64'(err_count), 64'(15'd0));
        chk("rst_first_err_addr", 64'(first_err_addr), 64'(17'h0));
        chk("rst_bus", 64'({avm.avm_chipselect, avm.avm_write, avm.avm_read}), 64'(3'b000));
        chk("rst_addr", 64'(avm.avm_address), 64'(17'h0));
        chk("rst_wdata", 64'(avm.avm_writedata), 64'(32'h0));
        chk("byteenable", 64'(avm.avm_byteenable), 64'(4'hF));
        reset_n = 1'b1;
        @(negedge clk);

        // Vector table
        for (int i = 0; i < 9; i++) begin
            if (vecs[i].corrupt >= 0) begin
                widx = vecs[i].base[16:2] + 15'(vecs[i].corrupt);
                mem[widx] = 32'h0;
            end
            clear_logs();
            run_cmd(vecs[i].op, vecs[i].base, vecs[i].n, vecs[i].seed, vecs[i].incr, lat, timed_out, busy_first);
            chk($sformatf("v%0d_timeout", i), 64'(timed_out), 64'(1'b0));
            chk($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
            chk($sformatf("v%0d_busy", i), 64'(busy_first), 64'(1'b1));
            chk($sformatf("v%0d_busy_at_done", i), 64'(busy), 64'(1'b0));
            chk($sformatf("v%0d_err_count", i), 64'(err_count), 64'(vecs[i].exp_err));
            if (vecs[i].exp_err != 15'd0)
                chk($sformatf("v%0d_first_err_addr", i), 64'(first_err_addr), 64'(vecs[i].exp_fea));
            chk($sformatf("v%0d_nwrites", i), 64'(wr_addr_q.size()), 64'(vecs[i].exp_nwr));
            if (vecs[i].exp_nwr > 0 && wr_addr_q.size() == vecs[i].exp_nwr) begin
                chk($sformatf("v%0d_first_addr", i), 64'(wr_addr_q[0]), 64'(vecs[i].exp_first_a));
                chk($sformatf("v%0d_first_data", i), 64'(wr_data_q[0]), 64'(vecs[i].exp_first_d));
                chk($sformatf("v%0d_last_addr", i), 64'(wr_addr_q[vecs[i].exp_nwr-1]), 64'(vecs[i].exp_last_a));
                chk($sformatf("v%0d_last_data", i), 64'(wr_data_q[vecs[i].exp_nwr-1]), 64'(vecs[i].exp_last_d));
                chk($sformatf("v%0d_consecutive", i), 64'(wr_cyc_q[vecs[i].exp_nwr-1] - wr_cyc_q[0]), 64'(vecs[i].exp_nwr - 1));
            end
            chk($sformatf("v%0d_outst_max", i), 64'(outst_max <= 4), 64'(1'b1));
            @(negedge clk);
            chk($sformatf("v%0d_done_pulse", i), 64'(done), 64'(1'b0));
        end

        // Zero-length command: done without bus traffic, errors cleared
        cs_before = cs_seen;
        run_cmd(1'b0, 17'h00400, 15'd0, 32'h5555AAAA, 1'b1, lat, timed_out, busy_first);
        chk("n0_timeout", 64'(timed_out), 64'(1'b0));
        chk("n0_latency", 64'(lat), 64'(1));
        chk("n0_busy", 64'(busy_first), 64'(1'b0));
        chk("n0_err_cleared", 64'(err_count), 64'(15'd0));
        @(negedge clk);
        chk("n0_no_cs", 64'(cs_seen - cs_before), 64'(0));

        // Write stall on word 1 for 3 clocks, with an ignored start while busy
        clear_logs();
        rd_before = rd_cnt;
        @(negedge clk);
        op = 1'b0; base_addr = 17'h00300; num_words = 15'd3; seed = 32'h11110000; incr = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        avm.avm_waitrequest = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk("stall_addr", 64'(avm.avm_address), 64'(17'h00304));
            chk("stall_data", 64'(avm.avm_writedata), 64'(32'h11110001));
            chk("stall_req", 64'({avm.avm_chipselect, avm.avm_write}), 64'(2'b11));
            if (k == 1) begin
                op = 1'b1; base_addr = 17'h00800; num_words = 15'd7; start = 1'b1;
            end
            @(negedge clk);
            start = 1'b0;
        end
        avm.avm_waitrequest = 1'b0;
        wt = 0;
        while (!done && wt < 50) begin
            @(negedge clk);
            wt++;
        end
        chk("stall_done", 64'(done), 64'(1'b1));
        chk("stall_nwrites", 64'(wr_addr_q.size()), 64'(3));
        if (wr_addr_q.size() == 3) begin
            chk("stall_w0", 64'({wr_addr_q[0], wr_data_q[0]}), {15'd0, 17'h00300, 32'h11110000});
            chk("stall_w1", 64'({wr_addr_q[1], wr_data_q[1]}), {15'd0, 17'h00304, 32'h11110001});
            chk("stall_w2", 64'({wr_addr_q[2], wr_data_q[2]}), {15'd0, 17'h00308, 32'h11110002});
        end
        chk("stall_no_reads", 64'(rd_cnt - rd_before), 64'(0));

        // Read throttling at MAX_OUT
        run_cmd(1'b0, 17'h00500, 15'd6, 32'h0000C000, 1'b1, lat, timed_out, busy_first);
        chk("fill500_timeout", 64'(timed_out), 64'(1'b0));
        clear_logs();
        rd_before = rd_cnt;
        rsp_en = 1'b0;
        @(negedge clk);
        op = 1'b1; base_addr = 17'h00500; num_words = 15'd6; seed = 32'h0000C000; incr = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        chk("maxout_outstanding", 64'(outst_m), 64'(4));
        chk("maxout_issued", 64'(rd_cnt - rd_before), 64'(4));
        chk("maxout_read_low", 64'({avm.avm_chipselect, avm.avm_read}), 64'(2'b00));
        chk("maxout_busy", 64'(busy), 64'(1'b1));
        rsp_en = 1'b1;
        wt = 0;
        while (!done && wt < 50) begin
            @(negedge clk);
            wt++;
        end
        chk("maxout_done", 64'(done), 64'(1'b1));
        chk("maxout_err", 64'(err_count), 64'(15'd0));
        chk("maxout_reads", 64'(rd_cnt - rd_before), 64'(6));
        chk("maxout_peak", 64'(outst_max), 64'(4));

        // Reset mid-READ with 3 reads outstanding
        rsp_en = 1'b0;
        @(negedge clk);
        op = 1'b1; base_addr = 17'h00500; num_words = 15'd6; seed = 32'h0000C000; incr = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        avm.avm_waitrequest = 1'b1;
        chk("rstmid_outstanding", 64'(outst_m), 64'(3));
        chk("rstmid_read_pending", 64'({avm.avm_chipselect, avm.avm_read, busy}), 64'(3'b111));
        #2;
        reset_n = 1'b0;
        #1;
        chk("rstmid_busy_done", 64'({busy, done}), 64'(2'b00));
        chk("rstmid_bus", 64'({avm.avm_chipselect, avm.avm_write, avm.avm_read}), 64'(3'b000));
        chk("rstmid_addr", 64'(avm.avm_address), 64'(17'h0));
        chk("rstmid_wdata", 64'(avm.avm_writedata), 64'(32'h0));
        chk("rstmid_err", 64'({err_count, first_err_addr}), 64'(0));
        rsp_q.delete();
        outst_m = 0;
        rsp_en = 1'b1;
        avm.avm_waitrequest = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        rd_before = rd_cnt;
        run_cmd(1'b1, 17'h00500, 15'd6, 32'h0000C000, 1'b1, lat, timed_out, busy_first);
        chk("restart_timeout", 64'(timed_out), 64'(1'b0));
        chk("restart_latency", 64'(lat), 64'(9));
        chk("restart_err", 64'(err_count), 64'(15'd0));
        chk("restart_reads", 64'(rd_cnt - rd_before), 64'(6));

        chk("bus_rules", 64'(viol), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
